meas_framer: RTL and testbench

//  Collects measurement samples and the PSU ADC reading into one 98-byte telemetry frame.

---
 rtl/simps_pkg.sv | 21 ++
 rtl/meas_buf.sv | 35 +++
 rtl/meas_framer.sv | 190 +++++++++++++++++++
 tb/tb_meas_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simps_pkg.sv
// ---------------------------------------------------------------------------
// simps_pkg
//  Shared constants and types for the telemetry path.
//  MEAS_FRAME_BYTES : length of a measurement frame with the default 46 samples
//  MEAS_SYNC        : default frame header byte
//  FLAGS_OVR_BIT    : position of the overrun flag inside the flags byte
//  mf_state_t       : measurement framer state
// ---------------------------------------------------------------------------
package simps_pkg;

    localparam int         MEAS_FRAME_BYTES = 98;
    localparam logic [7:0] MEAS_SYNC        = 8'hA5;
    localparam int         FLAGS_OVR_BIT    = 7;

    typedef enum logic [1:0] {
        MF_IDLE,
        MF_CAPTURE,
        MF_SEND
    } mf_state_t;

endpackage

// File: rtl/meas_buf.sv
// ---------------------------------------------------------------------------
// meas_buf
//  Simple dual-port sample store: one write port, one registered read port
//  with a single cycle of read latency.
//  Ports:
//   CLK_25M  in            clock
//   i_we     in            write enable
//   i_waddr  in  [AW-1:0]  write address
//   i_wdata  in  [W-1:0]   write data
//   i_raddr  in  [AW-1:0]  read address (sampled every cycle)
//   o_rdata  out [W-1:0]   word at i_raddr of the previous cycle
// ---------------------------------------------------------------------------
module meas_buf #(
    parameter int DEPTH = 46,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK_25M,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK_25M) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/meas_framer.sv
// ---------------------------------------------------------------------------
// meas_framer
//  Captures SAMPLES measurement samples (keeping one of every DECIM strobes),
//  latches the PSU reading and top-level state, then streams a
//  6+2*SAMPLES byte frame to the protocol engine with a valid/ready handshake.
//  Frame: SYNC, seq, ps hi, ps lo, {hi,lo} per sample, flags, XOR checksum.
//  Ports:
//   CLK_25M       in       clock
//   reset         in       synchronous, active-high
//   arm           in       keep capturing and emitting frames
//   sample_valid  in       one-cycle strobe for sample_data
//   sample_data   in  [11:0] measurement sample
//   ps_dig        in  [9:0]  PSU ADC reading
//   controlstate  in  [3:0]  top-level FSM state
//   frame_data    out [7:0]  current frame byte (0 when not valid)
//   frame_valid   out      frame_data valid
//   frame_ready   in       consumer takes the byte when valid && ready
//   frame_last    out      high with the checksum byte
//   busy          out      framer not idle
//   overrun       out      sticky: a kept sample arrived while sending
// ---------------------------------------------------------------------------
module meas_framer
    import simps_pkg::*;
#(
    parameter int         SAMPLES   = 46,
    parameter int         DECIM     = 1,
    parameter logic [7:0] SYNC_BYTE = MEAS_SYNC
) (
    input  logic        CLK_25M,
    input  logic        reset,
    input  logic        arm,
    input  logic        sample_valid,
    input  logic [11:0] sample_data,
    input  logic [9:0]  ps_dig,
    input  logic [3:0]  controlstate,
    output logic [7:0]  frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_last,
    output logic        busy,
    output logic        overrun
);

    localparam int             FRAME_BYTES = 6 + 2 * SAMPLES;
    localparam int             IW          = $clog2(SAMPLES);
    localparam int             BW          = $clog2(FRAME_BYTES);
    localparam logic [BW-1:0]  LAST_B      = BW'(FRAME_BYTES - 1);
    localparam logic [BW-1:0]  FLAG_B      = BW'(FRAME_BYTES - 2);
    localparam logic [IW-1:0]  LAST_IDX    = IW'(SAMPLES - 1);
    localparam logic [7:0]     DECIM_MAX   = 8'(DECIM - 1);

    mf_state_t      r_state, w_next;
    logic [IW-1:0]  r_idx;
    logic [7:0]     r_decim;
    logic [BW-1:0]  r_b;
    logic [7:0]     r_seq;
    logic [7:0]     r_csum;
    logic           r_ovr;
    logic [9:0]     r_ps;
    logic [3:0]     r_cs;

    logic           w_keep, w_cap_wr, w_cap_done, w_accept, w_frame_end;
    logic [BW-1:0]  w_b_next;
    logic [IW-1:0]  w_rd_addr;
    logic [11:0]    w_rd_data;
    logic [7:0]     w_flags, w_byte;

    // Sample index carried by frame byte b (bytes outside the sample area
    // map to a harmless in-range address).
    function automatic logic [IW-1:0] b_to_k(input logic [BW-1:0] b);
        logic [BW-1:0] off;
        if (b < BW'(4)) return '0;
        off = (b - BW'(4)) >> 1;
        if (off > BW'(SAMPLES - 1)) return LAST_IDX;
        return off[IW-1:0];
    endfunction

    assign w_keep      = sample_valid && (r_decim == 8'd0);
    assign w_cap_wr    = (r_state == MF_CAPTURE) && arm && w_keep;
    assign w_cap_done  = w_cap_wr && (r_idx == LAST_IDX);
    assign w_accept    = (r_state == MF_SEND) && frame_ready;
    assign w_frame_end = w_accept && (r_b == LAST_B);

    // Read address follows the byte index of the coming cycle so the RAM
    // word is already there when its byte is presented: no bubbles.
    always_comb begin
        w_b_next = '0;
        if (r_state == MF_SEND) begin
            if (!w_accept)      w_b_next = r_b;
            else if (!w_frame_end) w_b_next = r_b + BW'(1);
        end
        w_rd_addr = b_to_k(w_b_next);
    end

    meas_buf #(.DEPTH(SAMPLES), .WIDTH(12), .AW(IW)) u_buf (
        .CLK_25M (CLK_25M),
        .i_we    (w_cap_wr),
        .i_waddr (r_idx),
        .i_wdata (sample_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            MF_IDLE:    if (arm) w_next = MF_CAPTURE;
            MF_CAPTURE: begin
                if (!arm)            w_next = MF_IDLE;
                else if (w_cap_done) w_next = MF_SEND;
            end
            MF_SEND:    if (w_frame_end) w_next = arm ? MF_CAPTURE : MF_IDLE;
            default:    w_next = MF_IDLE;
        endcase
    end

    always_comb begin
        w_flags                = '0;
        w_flags[3:0]           = r_cs;
        w_flags[FLAGS_OVR_BIT] = r_ovr;
    end

    // Byte mux: everything comes from registers, so the byte is stable
    // for as long as the consumer stalls.
    always_comb begin
        w_byte = '0;
        if (r_state == MF_SEND) begin
            if (r_b == BW'(0))       w_byte = SYNC_BYTE;
            else if (r_b == BW'(1))  w_byte = r_seq;
            else if (r_b == BW'(2))  w_byte = {6'b0, r_ps[9:8]};
            else if (r_b == BW'(3))  w_byte = r_ps[7:0];
            else if (r_b == FLAG_B)  w_byte = w_flags;
            else if (r_b == LAST_B)  w_byte = r_csum;
            else if (!r_b[0])        w_byte = {4'b0, w_rd_data[11:8]};
            else                     w_byte = w_rd_data[7:0];
        end
    end

    always_ff @(posedge CLK_25M) begin
        if (reset) begin
            r_state <= MF_IDLE;
            r_idx   <= '0;
            r_decim <= '0;
            r_b     <= '0;
            r_seq   <= '0;
            r_csum  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (sample_valid) begin
                r_decim <= (r_decim == DECIM_MAX) ? 8'd0 : r_decim + 8'd1;
            end
            if ((r_state == MF_IDLE) && arm) begin
                r_decim <= '0;
                r_idx   <= '0;
            end
            if (w_cap_wr) begin
                r_idx <= w_cap_done ? '0 : r_idx + IW'(1);
            end
            if ((r_state == MF_SEND) && w_keep) begin
                r_ovr <= 1'b1;
            end
            if (w_accept) begin
                if (w_frame_end) begin
                    r_b    <= '0;
                    r_csum <= '0;
                    r_seq  <= r_seq + 8'd1;
                end else begin
                    r_b    <= r_b + BW'(1);
                    r_csum <= r_csum ^ w_byte;
                end
            end
        end
    end

    // Snapshot taken together with the final sample write.
    always_ff @(posedge CLK_25M) begin
        if (w_cap_done) begin
            r_ps <= ps_dig;
            r_cs <= controlstate;
        end
    end

    assign frame_data  = w_byte;
    assign frame_valid = (r_state == MF_SEND);
    assign frame_last  = (r_state == MF_SEND) && (r_b == LAST_B);
    assign busy        = (r_state != MF_IDLE);
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_meas_framer.sv
module tb_meas_framer;

    logic        CLK_25M = 1'b0;
    logic        reset = 1'b1;
    logic        arm1 = 1'b0, arm4 = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic [9:0]  ps_dig = 10'h2B7;
    logic [3:0]  controlstate = 4'h9;
    logic        frame_ready = 1'b0;

    logic [7:0]  d1_data, d4_data;
    logic        d1_valid, d1_last, d1_busy, d1_ovr;
    logic        d4_valid, d4_last, d4_busy, d4_ovr;

    always #20 CLK_25M = ~CLK_25M;

    meas_framer #(.SAMPLES(46), .DECIM(1)) u_d1 (
        .CLK_25M(CLK_25M), .reset(reset), .arm(arm1),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .ps_dig(ps_dig), .controlstate(controlstate),
        .frame_data(d1_data), .frame_valid(d1_valid), .frame_ready(frame_ready),
        .frame_last(d1_last), .busy(d1_busy), .overrun(d1_ovr)
    );

    meas_framer #(.SAMPLES(46), .DECIM(4)) u_d4 (
        .CLK_25M(CLK_25M), .reset(reset), .arm(arm4),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .ps_dig(ps_dig), .controlstate(controlstate),
        .frame_data(d4_data), .frame_valid(d4_valid), .frame_ready(frame_ready),
        .frame_last(d4_last), .busy(d4_busy), .overrun(d4_ovr)
    );

    logic       sel = 1'b0;
    logic [7:0] ob_data;
    logic       ob_valid, ob_last;
    assign ob_data  = sel ? d4_data  : d1_data;
    assign ob_valid = sel ? d4_valid : d1_valid;
    assign ob_last  = sel ? d4_last  : d1_last;

    int checks = 0, failures = 0;
    logic [7:0] rx [98];
    logic       rxl [98];
    logic [7:0] exf [98];
    int         smp [46];
    int         n_rx, bad_hold, bubbles, last_err;

    typedef struct {
        int         idx;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic feed(input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = 12'(i * mul + add);
            @(negedge CLK_25M);
        end
        sample_valid = 1'b0;
    endtask

    // Collect one frame (or stop_after bytes) from the selected DUT.
    task automatic recv(input bit rnd, input int stop_after);
        logic       v, l, rdy, prev_hold;
        logic [7:0] d, prev_data;
        n_rx = 0; bad_hold = 0; bubbles = 0; last_err = 0;
        prev_hold = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 2000 && n_rx < 98 && !(stop_after > 0 && n_rx >= stop_after); cyc++) begin
            v = ob_valid; d = ob_data; l = ob_last;
            if (prev_hold && (!v || d !== prev_data)) bad_hold++;
            if (v && (l !== (n_rx == 97))) last_err++;
            if (!v && n_rx > 0) bubbles++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            frame_ready = rdy;
            if (v && rdy) begin
                rx[n_rx]  = d;
                rxl[n_rx] = l;
                n_rx++;
            end
            prev_hold = v && !rdy;
            prev_data = d;
            @(negedge CLK_25M);
        end
        frame_ready = 1'b0;
    endtask

    task automatic build_exp(input logic [7:0] seq, input logic ovr);
        logic [7:0]  x;
        logic [11:0] s;
        exf[0] = 8'hA5;
        exf[1] = seq;
        exf[2] = {6'b0, ps_dig[9:8]};
        exf[3] = ps_dig[7:0];
        for (int k = 0; k < 46; k++) begin
            s = 12'(smp[k]);
            exf[4 + 2 * k] = {4'b0, s[11:8]};
            exf[5 + 2 * k] = s[7:0];
        end
        exf[96] = {ovr, 3'b0, controlstate};
        x = '0;
        for (int i = 0; i < 97; i++) x = x ^ exf[i];
        exf[97] = x;
    endtask

    task automatic cmp_frame(input string name);
        int nm;
        nm = 0;
        for (int i = 0; i < 98; i++) if (rx[i] !== exf[i]) nm++;
        check({name, "_count"}, n_rx, 98);
        check({name, "_bytes_wrong"}, nm, 0);
        check({name, "_last_err"}, last_err, 0);
    endtask

    task automatic set_smp(input int mul, input int add);
        for (int k = 0; k < 46; k++) smp[k] = (k * mul + add) & 12'hFFF;
    endtask

    initial begin
        int lat, vcnt;
        logic [7:0] x;

        vecs[0]  = '{0,  8'hA5, 1'b0};
        vecs[1]  = '{1,  8'h00, 1'b0};
        vecs[2]  = '{2,  8'h02, 1'b0};
        vecs[3]  = '{3,  8'hB7, 1'b0};
        vecs[4]  = '{4,  8'h00, 1'b0};
        vecs[5]  = '{5,  8'h00, 1'b0};
        vecs[6]  = '{6,  8'h00, 1'b0};
        vecs[7]  = '{7,  8'h01, 1'b0};
        vecs[8]  = '{94, 8'h00, 1'b0};
        vecs[9]  = '{95, 8'h2D, 1'b0};
        vecs[10] = '{96, 8'h09, 1'b0};
        vecs[11] = '{97, 8'h18, 1'b1};

        // Reset values
        repeat (3) @(negedge CLK_25M);
        check("rst_valid", d1_valid, 0);
        check("rst_last", d1_last, 0);
        check("rst_data", d1_data, 0);
        check("rst_busy", d1_busy, 0);
        check("rst_overrun", d1_ovr, 0);
        reset = 1'b0;
        @(negedge CLK_25M);

        // 1) basic frame, ready held high
        arm1 = 1'b1;
        @(negedge CLK_25M);
        check("busy_capture", d1_busy, 1);
        feed(46, 1, 0);
        lat = 0;
        while (!d1_valid && lat < 3) begin
            @(negedge CLK_25M);
            lat++;
        end
        check("first_byte_latency_ok", (lat <= 2), 1);
        recv(0, 0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t1_byte%0d", vecs[i].idx), rx[vecs[i].idx], vecs[i].exp_data);
            check($sformatf("t1_last%0d", vecs[i].idx), rxl[vecs[i].idx], vecs[i].exp_last);
        end
        set_smp(1, 0);
        build_exp(8'h00, 1'b0);
        cmp_frame("t1_frame");
        check("t1_bubbles", bubbles, 0);

        // 2) random ready back-pressure
        feed(46, 1, 0);
        recv(1, 0);
        build_exp(8'h01, 1'b0);
        cmp_frame("t2_frame");
        check("t2_hold_violations", bad_hold, 0);

        // 3) strobes during SEND -> overrun
        feed(46, 3, 5);
        fork
            recv(0, 0);
            feed(5, 1, 0);
        join
        check("t3_overrun", d1_ovr, 1);
        check("t3_seq", rx[1], 8'h02);
        x = '0;
        for (int i = 0; i < 97; i++) x = x ^ rx[i];
        check("t3_checksum", rx[97], x);
        feed(46, 2, 1);
        recv(0, 0);
        set_smp(2, 1);
        build_exp(8'h03, 1'b1);
        cmp_frame("t3_next_frame");
        check("t3_overrun_sticky", d1_ovr, 1);

        // 6a) abort capture -> idle, no frame, seq unchanged
        feed(20, 1, 0);
        arm1 = 1'b0;
        @(negedge CLK_25M);
        check("abort_busy", d1_busy, 0);
        vcnt = 0;
        repeat (10) begin
            @(negedge CLK_25M);
            if (d1_valid) vcnt++;
        end
        check("abort_no_frame", vcnt, 0);
        arm1 = 1'b1;
        @(negedge CLK_25M);
        feed(46, 5, 2);
        fork
            recv(0, 0);
            begin
                @(negedge CLK_25M);
                arm1 = 1'b0;
            end
        join
        set_smp(5, 2);
        build_exp(8'h04, 1'b1);
        cmp_frame("t6_after_abort");
        check("disarm_idle_after_frame", d1_busy, 0);

        // 5) decimation by 4
        sel = 1'b1;
        arm4 = 1'b1;
        @(negedge CLK_25M);
        feed(184, 1, 0);
        recv(0, 0);
        set_smp(4, 0);
        build_exp(8'h00, 1'b0);
        cmp_frame("t5_decim4");
        check("t5_no_overrun", d4_ovr, 0);
        arm4 = 1'b0;
        sel = 1'b0;
        @(negedge CLK_25M);

        // 6b) reset in the middle of a frame
        arm1 = 1'b1;
        @(negedge CLK_25M);
        feed(46, 1, 0);
        recv(0, 50);
        check("t6_partial_count", n_rx, 50);
        reset = 1'b1;
        @(negedge CLK_25M);
        check("midrst_valid", d1_valid, 0);
        check("midrst_last", d1_last, 0);
        check("midrst_overrun", d1_ovr, 0);
        check("midrst_busy", d1_busy, 0);
        reset = 1'b0;
        @(negedge CLK_25M);

        // 4) 257 frames back to back: seq wraps
        for (int f = 0; f < 257; f++) begin
            feed(46, f, f + 1);
            recv(0, 0);
            set_smp(f, f + 1);
            build_exp(8'(f), 1'b0);
            cmp_frame($sformatf("t4_frame%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
